hazard_ctrl: RTL and testbench

- Pipeline sequencer for the 5-stage 64-bit MIPS core.
- Generates the forward selects for the ID-stage operand muxes.
- Generates stall and flush for the IF/ID and ID/EX registers.
- Sequences multi-cycle mul/div occupancy and exception/ERET pipeline drains through a small FSM.
- Sits beside the ID stage. Inputs come from decoded fields of IF, EX, MEM and WB.

---
 rtl/hazard_ctrl_if.sv | 52 +++++
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Shared forwarding-select type and the ID-stage hazard bus bundle.
// The hazard controller sits on the slave side. The pipeline, or a bench,
// sits on the master side.
package hazard_pkg;
    typedef enum logic [1:0] {
        FWD_REGFILE = 2'd0,
        FWD_MEM     = 2'd1,
        FWD_WB      = 2'd2
    } forward_type_t;
endpackage

interface hazard_ctrl_if;
    import hazard_pkg::*;

    logic [4:0]    ID_rs;
    logic [4:0]    ID_rt;
    logic          ID_uses_rs;
    logic          ID_uses_rt;
    logic          ID_muldiv;
    logic [4:0]    EX_regnum;
    logic          EX_write_enable;
    logic [4:0]    MEM_regnum;
    logic          MEM_write_enable;
    logic          MEM_mem_read;
    logic [4:0]    WB_regnum;
    logic          WB_write_enable;
    logic          exc_req;
    logic          eret;
    forward_type_t forward_A;
    forward_type_t forward_B;
    logic          stall;
    logic          flush;
    logic          busy;

    modport master (
        output ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, ID_muldiv,
        output EX_regnum, EX_write_enable,
        output MEM_regnum, MEM_write_enable, MEM_mem_read,
        output WB_regnum, WB_write_enable,
        output exc_req, eret,
        input  forward_A, forward_B, stall, flush, busy
    );

    modport slave (
        input  ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, ID_muldiv,
        input  EX_regnum, EX_write_enable,
        input  MEM_regnum, MEM_write_enable, MEM_mem_read,
        input  WB_regnum, WB_write_enable,
        input  exc_req, eret,
        output forward_A, forward_B, stall, flush, busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core.
// It provides the ID operand forward selects and the stall/flush pair for
// IF/ID and ID/EX.
// It also sequences mul/div EX occupancy and exception/ERET drains.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULDIV_CYCLES = 8,
    parameter int DRAIN_CYCLES  = 2
) (
    input  logic          clock,
    input  logic          reset,
    hazard_ctrl_if.slave  bus
);

    localparam int MAX_CYCLES = (MULDIV_CYCLES > DRAIN_CYCLES) ? MULDIV_CYCLES : DRAIN_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_MULDIV,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic             redirect;
    logic             rs_ex, rs_ld, rs_mem, rs_wb;
    logic             rt_ex, rt_ld, rt_mem, rt_wb;
    logic             data_stall;
    forward_type_t    fwd_a_c, fwd_b_c;
    forward_type_t    sel_a, sel_b;
    logic             stall_c, flush_c, busy_c;

    // A used, nonzero source register matches a writing producer. $0 never matches.
    function automatic logic reg_hit(input logic       used,
                                     input logic [4:0] src,
                                     input logic       wen,
                                     input logic [4:0] dst);
        return used && (src != 5'd0) && wen && (dst == src);
    endfunction

    // Select a forward source. MEM wins over WB. Loads in MEM cannot forward.
    function automatic forward_type_t fwd_select(input logic mem_hit, input logic wb_hit);
        if (mem_hit)
            return FWD_MEM;
        else if (wb_hit)
            return FWD_WB;
        else
            return FWD_REGFILE;
    endfunction

    // Compare the ID sources against each downstream producer.
    always_comb begin
        rs_ex  = reg_hit(bus.ID_uses_rs, bus.ID_rs, bus.EX_write_enable, bus.EX_regnum);
        rs_ld  = reg_hit(bus.ID_uses_rs, bus.ID_rs, bus.MEM_write_enable & bus.MEM_mem_read, bus.MEM_regnum);
        rs_mem = reg_hit(bus.ID_uses_rs, bus.ID_rs, bus.MEM_write_enable & ~bus.MEM_mem_read, bus.MEM_regnum);
        rs_wb  = reg_hit(bus.ID_uses_rs, bus.ID_rs, bus.WB_write_enable, bus.WB_regnum);
        rt_ex  = reg_hit(bus.ID_uses_rt, bus.ID_rt, bus.EX_write_enable, bus.EX_regnum);
        rt_ld  = reg_hit(bus.ID_uses_rt, bus.ID_rt, bus.MEM_write_enable & bus.MEM_mem_read, bus.MEM_regnum);
        rt_mem = reg_hit(bus.ID_uses_rt, bus.ID_rt, bus.MEM_write_enable & ~bus.MEM_mem_read, bus.MEM_regnum);
        rt_wb  = reg_hit(bus.ID_uses_rt, bus.ID_rt, bus.WB_write_enable, bus.WB_regnum);
        // EX results are not on MEM_data yet, and load data appears only at WB.
        data_stall = rs_ex | rs_ld | rt_ex | rt_ld;
        sel_a      = fwd_select(rs_mem, rs_wb);
        sel_b      = fwd_select(rt_mem, rt_wb);
    end

    // Next state, counter and outputs, in priority order: redirect, drain, mul/div, data hazard, forwarding.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fwd_a_c  = FWD_REGFILE;
        fwd_b_c  = FWD_REGFILE;
        stall_c  = 1'b0;
        flush_c  = 1'b0;
        busy_c   = (state_q != S_RUN);
        redirect = bus.exc_req | bus.eret;

        if (redirect) begin
            // The redirect flushes this cycle. It also aborts any mul/div and (re)starts the drain.
            flush_c = 1'b1;
            state_d = S_DRAIN;
            cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
        end else begin
            case (state_q)
                S_RUN: begin
                    if (data_stall) begin
                        stall_c = 1'b1;
                    end else begin
                        fwd_a_c = sel_a;
                        fwd_b_c = sel_b;
                        if (bus.ID_muldiv) begin
                            state_d = S_MULDIV;
                            cnt_d   = CNT_W'(MULDIV_CYCLES - 1);
                        end
                    end
                end
                S_MULDIV: begin
                    // The issue cycle is already one of MULDIV_CYCLES, so leave as the count reaches zero.
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end
                end
                S_DRAIN: begin
                    flush_c = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = S_RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and occupancy counter. Reset returns to RUN at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Hold every output low while reset is high, with or without a clock edge.
    always_comb begin
        bus.forward_A = reset ? FWD_REGFILE : fwd_a_c;
        bus.forward_B = reset ? FWD_REGFILE : fwd_b_c;
        bus.stall     = stall_c & ~reset;
        bus.flush     = flush_c & ~reset;
        bus.busy      = busy_c  & ~reset;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus random traffic.
// A cycle-level reference model tracks how many mul/div and drain cycles remain.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int M = 8;
    localparam int D = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   md_left = 0;
    int   dr_left = 0;

    hazard_ctrl_if hif();

    hazard_ctrl #(.MULDIV_CYCLES(M), .DRAIN_CYCLES(D)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (hif.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        hif.ID_rs = 5'd0; hif.ID_rt = 5'd0; hif.ID_uses_rs = 1'b0; hif.ID_uses_rt = 1'b0;
        hif.ID_muldiv = 1'b0; hif.EX_regnum = 5'd0; hif.EX_write_enable = 1'b0;
        hif.MEM_regnum = 5'd0; hif.MEM_write_enable = 1'b0; hif.MEM_mem_read = 1'b0;
        hif.WB_regnum = 5'd0; hif.WB_write_enable = 1'b0; hif.exc_req = 1'b0; hif.eret = 1'b0;
    endtask

    function automatic bit dep(input logic used, input logic [4:0] src, input logic wen, input logic [4:0] dst);
        return used && src != 0 && wen && dst == src;
    endfunction

    function automatic bit m_hazard();
        bit h = 0;
        h |= dep(hif.ID_uses_rs, hif.ID_rs, hif.EX_write_enable, hif.EX_regnum);
        h |= dep(hif.ID_uses_rt, hif.ID_rt, hif.EX_write_enable, hif.EX_regnum);
        h |= dep(hif.ID_uses_rs, hif.ID_rs, hif.MEM_write_enable && hif.MEM_mem_read, hif.MEM_regnum);
        h |= dep(hif.ID_uses_rt, hif.ID_rt, hif.MEM_write_enable && hif.MEM_mem_read, hif.MEM_regnum);
        return h;
    endfunction

    function automatic logic [1:0] m_fwd(input logic used, input logic [4:0] src);
        if (dep(used, src, hif.MEM_write_enable && !hif.MEM_mem_read, hif.MEM_regnum)) return 2'd1;
        if (dep(used, src, hif.WB_write_enable, hif.WB_regnum)) return 2'd2;
        return 2'd0;
    endfunction

    task automatic check_model(input string tag);
        bit redirect, e_flush, e_busy, e_stall;
        logic [1:0] e_fa, e_fb;
        redirect = hif.exc_req || hif.eret;
        e_flush  = redirect || dr_left > 0;
        e_busy   = dr_left > 0 || md_left > 0;
        e_stall  = !e_flush && (md_left > 0 || m_hazard());
        e_fa     = (e_flush || e_stall) ? 2'd0 : m_fwd(hif.ID_uses_rs, hif.ID_rs);
        e_fb     = (e_flush || e_stall) ? 2'd0 : m_fwd(hif.ID_uses_rt, hif.ID_rt);
        if (reset) begin
            e_flush = 0; e_busy = 0; e_stall = 0; e_fa = 0; e_fb = 0;
        end
        chk({tag, ".fwdA"},  hif.forward_A, e_fa);
        chk({tag, ".fwdB"},  hif.forward_B, e_fb);
        chk({tag, ".stall"}, {1'b0, hif.stall}, {1'b0, e_stall});
        chk({tag, ".flush"}, {1'b0, hif.flush}, {1'b0, e_flush});
        chk({tag, ".busy"},  {1'b0, hif.busy},  {1'b0, e_busy});
    endtask

    task automatic adv();
        bit hz, redirect;
        hz       = m_hazard();
        redirect = hif.exc_req || hif.eret;
        @(posedge clock);
        if (reset) begin
            md_left = 0; dr_left = 0;
        end else if (redirect) begin
            dr_left = D; md_left = 0;
        end else if (dr_left > 0) begin
            dr_left--;
        end else if (md_left > 0) begin
            md_left--;
        end else if (hif.ID_muldiv && !hz) begin
            md_left = M - 1;
        end
        @(negedge clock);
    endtask

    task automatic step(input string tag);
        #1;
        check_model(tag);
    endtask

    initial begin
        clear_inputs();
        hif.exc_req = 1'b1;
        hif.ID_rs = 5'd4; hif.ID_uses_rs = 1'b1; hif.EX_regnum = 5'd4; hif.EX_write_enable = 1'b1;
        @(negedge clock);
        step("in_reset");
        chk("in_reset.flush_const", {1'b0, hif.flush}, 2'd0);
        adv();
        clear_inputs();
        reset = 1'b0;

        // No writers anywhere.
        hif.ID_rs = 5'd3; hif.ID_uses_rs = 1'b1;
        step("idle");
        chk("idle.fwdA_const", hif.forward_A, 2'd0);
        chk("idle.busy_const", {1'b0, hif.busy}, 2'd0);
        adv();

        // MEM and WB both write $5. MEM wins.
        hif.ID_rs = 5'd5; hif.MEM_regnum = 5'd5; hif.MEM_write_enable = 1'b1;
        hif.WB_regnum = 5'd5; hif.WB_write_enable = 1'b1;
        hif.ID_rt = 5'd0; hif.ID_uses_rt = 1'b1;
        step("fwd_mem");
        chk("fwd_mem.const", hif.forward_A, 2'd1);
        adv();
        hif.MEM_write_enable = 1'b0;
        step("fwd_wb");
        chk("fwd_wb.const", hif.forward_A, 2'd2);
        adv();
        hif.MEM_regnum = 5'd0; hif.MEM_write_enable = 1'b1;
        step("fwd_zero");
        chk("fwd_zero.const", hif.forward_B, 2'd0);
        adv();

        // A load to $7 walks from EX to MEM to WB while ID reads rt=7.
        clear_inputs();
        hif.ID_rt = 5'd7; hif.ID_uses_rt = 1'b1; hif.EX_regnum = 5'd7; hif.EX_write_enable = 1'b1;
        step("ld_ex");
        chk("ld_ex.const", {1'b0, hif.stall}, 2'd1);
        adv();
        hif.EX_write_enable = 1'b0;
        hif.MEM_regnum = 5'd7; hif.MEM_write_enable = 1'b1; hif.MEM_mem_read = 1'b1;
        step("ld_mem");
        chk("ld_mem.const", {1'b0, hif.stall}, 2'd1);
        adv();
        hif.MEM_write_enable = 1'b0; hif.MEM_mem_read = 1'b0;
        hif.WB_regnum = 5'd7; hif.WB_write_enable = 1'b1;
        step("ld_wb");
        chk("ld_wb.stall_const", {1'b0, hif.stall}, 2'd0);
        chk("ld_wb.fwdB_const", hif.forward_B, 2'd2);
        adv();

        // Mul/div issue, then M-1 stall cycles, then RUN.
        clear_inputs();
        hif.ID_muldiv = 1'b1;
        step("md_issue");
        adv();
        hif.ID_muldiv = 1'b0;
        for (int i = 0; i < M - 1; i++) begin
            step("md_occ");
            chk("md_occ.stall_const", {1'b0, hif.stall}, 2'd1);
            chk("md_occ.busy_const", {1'b0, hif.busy}, 2'd1);
            adv();
        end
        step("md_done");
        chk("md_done.stall_const", {1'b0, hif.stall}, 2'd0);
        chk("md_done.busy_const", {1'b0, hif.busy}, 2'd0);
        adv();

        // Exception on the 3rd mul/div cycle aborts it and drains for D cycles.
        hif.ID_muldiv = 1'b1;
        step("mdx_issue");
        adv();
        hif.ID_muldiv = 1'b0;
        step("mdx_c1"); adv();
        step("mdx_c2"); adv();
        hif.exc_req = 1'b1;
        step("mdx_exc");
        chk("mdx_exc.flush_const", {1'b0, hif.flush}, 2'd1);
        chk("mdx_exc.stall_const", {1'b0, hif.stall}, 2'd0);
        adv();
        hif.exc_req = 1'b0;
        for (int i = 0; i < D; i++) begin
            step("drain");
            chk("drain.flush_const", {1'b0, hif.flush}, 2'd1);
            adv();
        end
        step("drain_end");
        chk("drain_end.busy_const", {1'b0, hif.busy}, 2'd0);
        chk("drain_end.flush_const", {1'b0, hif.flush}, 2'd0);
        adv();

        // An ERET on drain cycle 1 restarts the drain.
        hif.exc_req = 1'b1;
        step("rex_exc"); adv();
        hif.exc_req = 1'b0; hif.eret = 1'b1;
        step("rex_eret"); adv();
        hif.eret = 1'b0;
        for (int i = 0; i < D; i++) begin
            step("rex_drain");
            chk("rex_drain.flush_const", {1'b0, hif.flush}, 2'd1);
            adv();
        end
        step("rex_end");
        chk("rex_end.flush_const", {1'b0, hif.flush}, 2'd0);
        adv();

        // Asynchronous reset in the middle of a drain.
        hif.eret = 1'b1;
        step("ar_eret"); adv();
        hif.eret = 1'b0;
        step("ar_drain");
        #2;
        reset = 1'b1;
        #1;
        chk("ar_async.flush", {1'b0, hif.flush}, 2'd0);
        chk("ar_async.busy", {1'b0, hif.busy}, 2'd0);
        adv();
        reset = 1'b0;
        step("ar_after"); adv();

        // Random traffic on a small register set so dependencies are frequent.
        for (int i = 0; i < 400; i++) begin
            hif.ID_rs            = 5'($urandom_range(0, 3));
            hif.ID_rt            = 5'($urandom_range(0, 3));
            hif.ID_uses_rs       = 1'($urandom_range(0, 1));
            hif.ID_uses_rt       = 1'($urandom_range(0, 1));
            hif.ID_muldiv        = ($urandom_range(0, 7) == 0);
            hif.EX_regnum        = 5'($urandom_range(0, 3));
            hif.EX_write_enable  = ($urandom_range(0, 3) == 0);
            hif.MEM_regnum       = 5'($urandom_range(0, 3));
            hif.MEM_write_enable = 1'($urandom_range(0, 1));
            hif.MEM_mem_read     = ($urandom_range(0, 3) == 0);
            hif.WB_regnum        = 5'($urandom_range(0, 3));
            hif.WB_write_enable  = 1'($urandom_range(0, 1));
            hif.exc_req          = ($urandom_range(0, 24) == 0);
            hif.eret             = ($urandom_range(0, 29) == 0);
            reset                = ($urandom_range(0, 99) == 0);
            step("rnd");
            adv();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
